// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier slice.
//   MULT_N     : default operand width
//   cntWidth() : width of the step counter for an N-bit operand
//   multCtrl_t : control bundle shared by the control unit and the datapath
package mult_pkg;

   localparam int unsigned MULT_N = 8;

   // The counter must hold N-1; never narrower than one bit.
   function automatic int unsigned cntWidth(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned MULT_CW = cntWidth(MULT_N);

   typedef struct packed {
      logic loadA;
      logic resetA;
      logic resetC;
      logic decC;
      logic shift;
   } multCtrl_t;

endpackage

// File: rtl/mult_step_counter.sv
// Step counter for the shift-add multiplier.
//   Clk, Reset (async, active low)
//   ResetC : preset count to N-1 (wins over DecC)
//   DecC   : decrement, saturating at zero
//   Z      : count == 0 (combinational)
module mult_step_counter
   import mult_pkg::*;
#(
   parameter int unsigned N = MULT_N
) (
   input  logic Clk,
   input  logic Reset,
   input  logic ResetC,
   input  logic DecC,
   output logic Z
);

   localparam int unsigned CW = cntWidth(N);

   logic [CW-1:0] countQ;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         countQ <= '0;
      end else if (ResetC) begin
         countQ <= CW'(N - 1);
      end else if (DecC && (countQ != '0)) begin
         countQ <= countQ - 1'b1;
      end
   end

   assign Z = (countQ == '0);

endmodule

// File: rtl/mult_datapath.sv
// Datapath of an unsigned shift-add multiplier.
//   Clk, Reset (async, active low)
//   DataIn  : shared operand bus (multiplicand via LoadB, multiplier via LoadQ)
//   LoadB, LoadQ, LoadA, ResetA, ResetC, DecC, Shift, LoadP : datapath controls
//   Z       : step counter is zero
//   Q0      : Q[0], selects whether the next step accumulates
//   Done    : only with MULT_DONE_EN; one-cycle pulse after the final step
//   Product : captured {A,Q}
module mult_datapath
   import mult_pkg::*;
#(
   parameter int unsigned N = MULT_N
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [N-1:0]   DataIn,
   input  logic           LoadB,
   input  logic           LoadQ,
   input  logic           LoadA,
   input  logic           ResetA,
   input  logic           ResetC,
   input  logic           DecC,
   input  logic           Shift,
   input  logic           LoadP,
   output logic           Z,
   output logic           Q0,
`ifdef MULT_DONE_EN
   output logic           Done,
`endif
   output logic [2*N-1:0] Product
);

   multCtrl_t ctrl;

   logic [N-1:0]   bQ;
   logic [N-1:0]   qQ;
   logic [N-1:0]   aQ;
   logic           eQ;
   logic [2*N-1:0] pQ;
   logic [N:0]     sum;
   logic           shiftIn;

   assign ctrl.loadA  = LoadA;
   assign ctrl.resetA = ResetA;
   assign ctrl.resetC = ResetC;
   assign ctrl.decC   = DecC;
   assign ctrl.shift  = Shift;

   assign sum = {1'b0, aQ} + {1'b0, bQ};

   // A clear in the same cycle as a shift means Q sees the cleared accumulator.
   assign shiftIn = ctrl.resetA ? 1'b0 : aQ[0];

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         bQ <= '0;
         qQ <= '0;
         aQ <= '0;
         eQ <= 1'b0;
         pQ <= '0;
      end else begin
         if (LoadB) begin
            bQ <= DataIn;
         end

         if (ctrl.resetA) begin
            {eQ, aQ} <= '0;
         end else if (ctrl.loadA) begin
            {eQ, aQ} <= sum;
         end else if (ctrl.shift) begin
            {eQ, aQ} <= {1'b0, eQ, aQ[N-1:1]};
         end

         if (LoadQ) begin
            qQ <= DataIn;
         end else if (ctrl.shift) begin
            qQ <= {shiftIn, qQ[N-1:1]};
         end

         if (LoadP) begin
            pQ <= {aQ, qQ};
         end
      end
   end

   mult_step_counter #(
      .N (N)
   ) uStepCounter (
      .Clk    (Clk),
      .Reset  (Reset),
      .ResetC (ctrl.resetC),
      .DecC   (ctrl.decC),
      .Z      (Z)
   );

`ifdef MULT_DONE_EN
   logic doneQ;

   // Z is the pre-edge count, so Shift+DecC with Z high is the last step.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         doneQ <= 1'b0;
      end else begin
         doneQ <= ctrl.shift && ctrl.decC && Z;
      end
   end

   assign Done = doneQ;
`endif

   assign Q0      = qQ[0];
   assign Product = pQ;

endmodule

// File: tb/tb_mult_datapath.sv
module tb_mult_datapath;

   localparam int N = 8;
   localparam int MASK = (1 << N) - 1;

   logic           Clk;
   logic           Reset;
   logic [N-1:0]   DataIn;
   logic           LoadB, LoadQ, LoadA, ResetA, ResetC, DecC, Shift, LoadP;
   logic           Z, Q0;
   logic [2*N-1:0] Product;
`ifdef MULT_DONE_EN
   logic           Done;
`endif

   int nAsserts = 0;
   int nFails   = 0;

   // Behavioural model state (plain integers)
   int mB, mQ, mA, mE, mC, mP, mDone;

   mult_datapath #(
      .N (N)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .DataIn  (DataIn),
      .LoadB   (LoadB),
      .LoadQ   (LoadQ),
      .LoadA   (LoadA),
      .ResetA  (ResetA),
      .ResetC  (ResetC),
      .DecC    (DecC),
      .Shift   (Shift),
      .LoadP   (LoadP),
      .Z       (Z),
      .Q0      (Q0),
`ifdef MULT_DONE_EN
      .Done    (Done),
`endif
      .Product (Product)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mB = 0; mQ = 0; mA = 0; mE = 0; mC = 0; mP = 0; mDone = 0;
   endtask

   task automatic chkOutputs(input string tag);
      chk({tag, ".Product"}, 32'(Product), 32'(mP));
      chk({tag, ".Z"}, 32'(Z), 32'(mC == 0));
      chk({tag, ".Q0"}, 32'(Q0), 32'(mQ % 2));
`ifdef MULT_DONE_EN
      chk({tag, ".Done"}, 32'(Done), 32'(mDone));
`endif
   endtask

   // One clock with the given controls; model advanced from pre-edge state.
   task automatic step(input logic lb, lq, la, ra, rc, dc, sh, lp, input int d, input string tag);
      int nB, nQ, nA, nE, nC, nP, nDone, wide, inBit;
      LoadB = lb; LoadQ = lq; LoadA = la; ResetA = ra;
      ResetC = rc; DecC = dc; Shift = sh; LoadP = lp;
      DataIn = N'(d);

      nB = lb ? (d & MASK) : mB;
      nA = mA; nE = mE;
      if (ra) begin
         nA = 0; nE = 0;
      end else if (la) begin
         nA = (mA + mB) % (1 << N);
         nE = ((mA + mB) >= (1 << N)) ? 1 : 0;
      end else if (sh) begin
         wide = (mE << (2 * N)) + (mA << N) + mQ;
         wide = wide / 2;
         nA = (wide >> N) & MASK;
         nE = 0;
      end
      nQ = mQ;
      if (lq) begin
         nQ = d & MASK;
      end else if (sh) begin
         inBit = ra ? 0 : (mA % 2);
         nQ = (mQ / 2) + inBit * (1 << (N - 1));
      end
      nC = rc ? (N - 1) : (dc ? ((mC > 0) ? mC - 1 : 0) : mC);
      nP = lp ? (mA * (1 << N) + mQ) : mP;
      nDone = (sh && dc && (mC == 0)) ? 1 : 0;

      @(posedge Clk);
      #1;
      mB = nB; mQ = nQ; mA = nA; mE = nE; mC = nC; mP = nP; mDone = nDone;
      chkOutputs(tag);
   endtask

   task automatic idle(input string tag);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   // Full multiply; optionally snapshot {A,Q} into P after every shift.
   task automatic runMult(input int b, input int q, input bit probe, input int stopAfter);
      step(1, 0, 0, 0, 0, 0, 0, 0, b, "ldB");
      step(0, 1, 0, 1, 1, 0, 0, 0, q, "ldQ");
      for (int i = 0; i < N && i < stopAfter; i++) begin
         if (mQ % 2 == 1) step(0, 0, 1, 0, 0, 0, 0, 0, 0, "add");
         step(0, 0, 0, 0, 0, 1, 1, 0, 0, "shift");
         if (probe) step(0, 0, 0, 0, 0, 0, 0, 1, 0, "probe");
         if (b == 255 && q == 255 && i == 1) chk("carryIntoA7", 32'(Product[15]), 32'd1);
      end
   endtask

   initial begin
      int a, b;
      modelReset();
      Reset = 1'b0;
      DataIn = '0;
      LoadB = 0; LoadQ = 0; LoadA = 0; ResetA = 0;
      ResetC = 0; DecC = 0; Shift = 0; LoadP = 0;
      #3;
      chkOutputs("resetState");
      #5 Reset = 1'b1;
      idle("holdAfterReset");

      // 13 x 11
      runMult(13, 11, 0, N);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, "ldP");
      chk("prod13x11", 32'(Product), 32'h008F);
      chk("zAfter13x11", 32'(Z), 32'd1);

      // Saturation at zero, then ResetC beating DecC
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, "decSat");
      chk("zSat", 32'(Z), 32'd1);
      step(0, 0, 0, 0, 1, 1, 0, 0, 0, "rcDc");
      chk("zAfterPreset", 32'(Z), 32'd0);
      for (int i = 0; i < N - 1; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0, "countDown");
      chk("zAfterCountDown", 32'(Z), 32'd1);

      // 255 x 255 with carry visible after the second add+shift
      runMult(255, 255, 1, N);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, "ldP");
      chk("prod255x255", 32'(Product), 32'hFE01);

      // ResetA+LoadA+Shift with A=5, Q=0xFF; LoadP alongside the shift sees pre-edge {A,Q}
      step(1, 1, 0, 1, 0, 0, 0, 0, 5, "ldB5");
      step(0, 1, 1, 0, 0, 0, 0, 0, 255, "aIs5");
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, "snapA5");
      chk("aIs5", 32'(Product), 32'h05FF);
      step(0, 0, 1, 1, 0, 0, 1, 1, 0, "raLaSh");
      chk("ldPPreEdge", 32'(Product), 32'h05FF);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, "snapAfter");
      chk("raLaShResult", 32'(Product), 32'h007F);

      // Random control mix
      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)),
              "rand");
      end

      // Random full multiplies against plain arithmetic
      for (int i = 0; i < 6; i++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         runMult(a, b, 0, N);
         step(0, 0, 0, 0, 0, 0, 0, 1, 0, "ldP");
         chk("prodRand", 32'(Product), 32'(a * b));
      end

      // Async reset after step 3 of a sequence
      runMult(200, 170, 1, 3);
      #3 Reset = 1'b0;
      modelReset();
      #1;
      chkOutputs("asyncReset");
      chk("asyncResetProduct", 32'(Product), 32'd0);
      #1 Reset = 1'b1;
      idle("holdAfterAbort");

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
